// File: rtl/note_input_if.sv
// note_input_if: note-entry bus; raw key/octave inputs toward the controller, displayed note/octave/ld_note/busy back
interface note_input_if;
  logic [11:0] key_in;
  logic oct_up;
  logic oct_down;
  logic [3:0] note;
  logic [1:0] octave;
  logic ld_note;
  logic busy;
  modport master(output key_in, oct_up, oct_down, input note, octave, ld_note, busy);
  modport slave(input key_in, oct_up, oct_down, output note, octave, ld_note, busy);
endinterface

// File: rtl/note_input_ctrl.sv
// note_input_ctrl: sync+debounce 12 keys and 2 octave buttons, stage note/octave, pulse ld_note then hold off; ports clk, reset, bus(key_in/oct_up/oct_down in; note/octave/ld_note/busy out)
module note_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LD_PULSE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  note_input_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2((LD_PULSE_CYCLES > HOLDOFF_CYCLES ? LD_PULSE_CYCLES : HOLDOFF_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
  state_t state, state_n;
  logic [13:0] raw, s1, s2, lvl, lvl_d, press;
  logic [DW-1:0] db_cnt [14];
  logic [FW-1:0] cnt, cnt_n;
  logic [3:0] note, note_n, snote, snote_n, key_sel;
  logic [1:0] octave, oct_n, soct, soct_n;
  logic ld_note, ld_n, pend, pend_n, key_ev, up, dn, pend_ev;
  assign raw = {bus.oct_down, bus.oct_up, bus.key_in};
  assign press = lvl & ~lvl_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 14; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      lvl_d <= lvl;
      for (int i = 0; i < 14; i++)
        if (s2[i] == lvl[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i] <= s2[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
    end
  end
  always_comb begin
    key_sel = '0;
    for (int i = 11; i >= 0; i--) if (press[i]) key_sel = 4'(i + 1);
    key_ev = |press[11:0];
    up = press[12] & ~press[13];
    dn = press[13] & ~press[12];
    soct_n = (up && soct != 2'd3) ? soct + 2'd1 : (dn && soct != 2'd0) ? soct - 2'd1 : soct;
    snote_n = key_ev ? key_sel : snote;
    pend_ev = key_ev | ((soct_n != soct) & (snote != 4'd0));
    state_n = state;
    cnt_n = cnt;
    note_n = note;
    oct_n = octave;
    ld_n = ld_note;
    pend_n = pend | pend_ev;
    if (state == IDLE && pend) begin
      state_n = PULSE;
      cnt_n = '0;
      note_n = snote;
      oct_n = soct;
      ld_n = 1'b1;
      pend_n = pend_ev;
    end else if (state == PULSE) begin
      if (cnt == FW'(LD_PULSE_CYCLES - 1)) begin
        state_n = HOLDOFF;
        cnt_n = '0;
        ld_n = 1'b0;
      end else cnt_n = cnt + 1'b1;
    end else if (state == HOLDOFF) begin
      if (cnt == FW'(HOLDOFF_CYCLES - 1)) begin
        state_n = IDLE;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      note <= '0;
      octave <= '0;
      ld_note <= 1'b0;
      pend <= 1'b0;
      snote <= '0;
      soct <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      note <= note_n;
      octave <= oct_n;
      ld_note <= ld_n;
      pend <= pend_n;
      snote <= snote_n;
      soct <= soct_n;
    end
  end
  assign bus.note = note;
  assign bus.octave = octave;
  assign bus.ld_note = ld_note;
  assign bus.busy = state != IDLE;
endmodule

// File: doc/note_input_ctrl.md
NOTE_INPUT_CTRL -- requirements
Module: note_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000; consecutive stable cycles (10 ms at 50 MHz) before a raw input is accepted.
REQ-002 Parameter LD_PULSE_CYCLES, default 4; width of each ld_note pulse in clocks.
REQ-003 Parameter HOLDOFF_CYCLES, default 1024; dead time after each pulse, which covers one clear-plus-draw pass of the downstream renderer (864 clocks).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 key_in  in  12  raw semitone keys; index 0..11 = A, A#, B, C, C#, D, D#, E, F, F#, G, G#; asynchronous and bouncy.
REQ-007 oct_up  in  1  raw octave-increment button; asynchronous and bouncy.
REQ-008 oct_down  in  1  raw octave-decrement button; asynchronous and bouncy.
REQ-009 note  out  4  displayed note code; 0 = none, 1..12 = key index+1; registered.
REQ-010 octave  out  2  displayed octave, 0..3; registered.
REQ-011 ld_note  out  1  load pulse to the note renderer; registered.
REQ-012 busy  out  1  high while state is PULSE or HOLDOFF.

Function
REQ-013 Each of the 14 raw inputs SHALL pass through a 2-flop synchronizer and then its own debounce counter.
REQ-014 Debounced level SHALL take the synchronized value once that value has differed from the current level for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear the counter.
REQ-015 Press event = debounced level 0->1; releases and held levels SHALL generate no events and no auto-repeat.
REQ-016 Key press SHALL set staged_note = index+1; if several keys press in the same cycle, the lowest index SHALL win.
REQ-017 oct_up press SHALL set staged_oct = staged_oct+1, saturating at 3; oct_down press SHALL set staged_oct = staged_oct-1, saturating at 0.
REQ-018 oct_up and oct_down pressed in the same cycle SHALL be ignored.
REQ-019 pending flag SHALL be set on the edge after any key press.
REQ-020 pending flag SHALL also be set on the edge after an octave press, but only if staged_oct actually changed and staged_note != 0.
REQ-021 Key and octave events in the same cycle SHALL both apply to the staged values and SHALL set pending once.
REQ-022 FSM states SHALL be IDLE, PULSE, HOLDOFF, with a cycle counter cleared on every state entry.
REQ-023 IDLE with pending=1 -> PULSE: on that edge, note<=staged_note, octave<=staged_oct, ld_note<=1, pending<=0.
REQ-024 PULSE -> HOLDOFF after LD_PULSE_CYCLES cycles with ld_note=1; ld_note<=0 on entry to HOLDOFF.
REQ-025 HOLDOFF -> IDLE after HOLDOFF_CYCLES cycles.
REQ-026 note and octave SHALL be stable while busy=1.
REQ-027 Events while busy SHALL update staged values and pending, last value wins; no event is lost beyond one-deep merging.
REQ-028 An event whose debounced edge occurs at edge E with FSM in IDLE SHALL produce ld_note=1 from edge E+2.
REQ-029 Counters SHALL hold until their compare values; no wrap-around.

Reset
REQ-030 reset=1 at a clock edge SHALL set note=0, octave=0, ld_note=0, busy=0, state=IDLE, pending=0, staged_note=0, staged_oct=0, all debounce levels, counters and synchronizers to 0.
REQ-031 reset SHALL take effect from any state, including mid-PULSE, with outputs 0 on the next edge.
REQ-032 Raw inputs held high through reset release SHALL be re-debounced and yield one press event.

Verification (DEBOUNCE_CYCLES=4, LD_PULSE_CYCLES=2, HOLDOFF_CYCLES=8)
REQ-033 key_in[2] held 12 cycles -> note=0011, octave=00, ld_note high exactly 2 cycles, busy high 10 cycles, single pulse.
REQ-034 key_in[0] toggled every 2 cycles for 24 cycles -> ld_note never asserts; note stays 0.
REQ-035 After note A, 4 clean oct_up presses -> octave 1,2,3 with a pulse each; 4th press gives no pulse, octave stays 3.
REQ-036 key_in[4] press, then key_in[7] press during HOLDOFF -> second pulse starts the cycle after IDLE entry with note=1000; outputs do not change during first busy.
REQ-037 key_in[3] and key_in[9] debounce in the same cycle -> note=0100 and exactly one pulse.
REQ-038 reset asserted during PULSE -> next edge ld_note=0, busy=0, note=0, octave=0; no further pulse without a new press.
